// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage.
// Load size encoding and register-file addressing.
package writeback_pkg;

  typedef enum logic [1:0] {
    LS_BYTE  = 2'd0,
    LS_HALF  = 2'd1,
    LS_WORD  = 2'd2,
    LS_DWORD = 2'd3
  } load_size_e;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Load data extraction: shift by byte offset, select size, extend.
// Bytes past the top of the bus shift in as zero (no wrap).
module load_align
  import writeback_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0]           i_data,
  input  logic [$clog2(W/8)-1:0] i_off,
  input  load_size_e             i_size,
  input  logic                   i_unsigned,
  output logic [W-1:0]           o_data
);

  logic [W-1:0] w_shift;

  assign w_shift = i_data >> {i_off, 3'b000};

  always_comb begin
    o_data = '0;
    unique case (i_size)
      LS_BYTE: begin
        if (i_unsigned) o_data = W'(w_shift[7:0]);
        else            o_data = W'($signed(w_shift[7:0]));
      end
      LS_HALF: begin
        if (i_unsigned) o_data = W'(w_shift[15:0]);
        else            o_data = W'($signed(w_shift[15:0]));
      end
      LS_WORD: begin
        if (i_unsigned) o_data = W'(w_shift[31:0]);
        else            o_data = W'($signed(w_shift[31:0]));
      end
      LS_DWORD: o_data = W'($signed(w_shift[63:0]));
    endcase
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Registered writeback stage arbitrating pipeline vs long-latency results.
// Optional WB_FORWARD_EN exposes the pre-register write for decode bypass.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int CNT_WIDTH      = 64,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  input  logic                            in_mem_or_reg,
  input  logic [BUS_DATA_WIDTH-1:0]       in_read_data,
  input  logic [BUS_DATA_WIDTH-1:0]       in_alu_data,
  input  logic [$clog2(BUS_DATA_WIDTH/8)-1:0] in_byte_off,
  input  logic [1:0]                      in_load_size,
  input  logic                            in_load_unsigned,
  input  logic [REG_ADDR_W-1:0]           in_dest_reg,
  input  logic                            in_reg_write,
  input  logic                            lq_valid,
  input  logic [BUS_DATA_WIDTH-1:0]       lq_data,
  input  logic [REG_ADDR_W-1:0]           lq_dest_reg,
  output logic                            lq_ready,
  output logic                            stall_req,
  output logic                            out_reg_write,
  output logic [REG_ADDR_W-1:0]           out_dest_reg,
  output logic [BUS_DATA_WIDTH-1:0]       out_mem_or_reg_data,
  output logic [CNT_WIDTH-1:0]            out_retire_count
`ifdef WB_FORWARD_EN
  ,
  output logic                            fwd_valid,
  output logic [REG_ADDR_W-1:0]           fwd_dest_reg,
  output logic [BUS_DATA_WIDTH-1:0]       fwd_data
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic                      w_p_claim;
  logic                      w_lq_wr;
  logic                      w_we;
  logic [REG_ADDR_W-1:0]     w_dest;
  logic [BUS_DATA_WIDTH-1:0] w_load;
  logic [BUS_DATA_WIDTH-1:0] w_pipe;
  logic [BUS_DATA_WIDTH-1:0] w_data;
  logic [SW-1:0]             w_starve_nxt;

  logic                      r_we;
  logic [REG_ADDR_W-1:0]     r_dest;
  logic [BUS_DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic [SW-1:0]             r_starve;
  logic                      r_stall;

  load_align #(.W(BUS_DATA_WIDTH)) u_align (
    .i_data     (in_read_data),
    .i_off      (in_byte_off),
    .i_size     (load_size_e'(in_load_size)),
    .i_unsigned (in_load_unsigned),
    .o_data     (w_load)
  );

  assign w_p_claim = in_valid & in_reg_write & (in_dest_reg != REG_ZERO);
  assign w_lq_wr   = ~w_p_claim & lq_valid & (lq_dest_reg != REG_ZERO);
  assign w_we      = w_p_claim | w_lq_wr;
  assign w_pipe    = in_mem_or_reg ? in_alu_data : w_load;
  assign w_dest    = w_p_claim ? in_dest_reg : lq_dest_reg;
  assign w_data    = w_p_claim ? w_pipe : lq_data;

  // Pipeline always wins; lq is held off, never the pipeline
  assign lq_ready  = reset_n & lq_valid & ~w_p_claim;

  always_comb begin
    w_starve_nxt = '0;
    if (lq_valid && !lq_ready) begin
      if (r_starve == LIMIT) w_starve_nxt = r_starve;
      else                   w_starve_nxt = r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we     <= 1'b0;
      r_dest   <= REG_ZERO;
      r_data   <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_we     <= w_we;
      r_cnt    <= r_cnt + CNT_WIDTH'(in_valid);
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == LIMIT);
      if (w_we) begin
        r_dest <= w_dest;
        r_data <= w_data;
      end
    end
  end

  assign out_reg_write       = r_we;
  assign out_dest_reg        = r_dest;
  assign out_mem_or_reg_data = r_data;
  assign out_retire_count    = r_cnt;
  assign stall_req           = r_stall;

`ifdef WB_FORWARD_EN
  assign fwd_valid    = reset_n & w_we;
  assign fwd_dest_reg = reset_n ? w_dest : REG_ZERO;
  assign fwd_data     = reset_n ? w_data : '0;
`endif

endmodule
